// File: rtl/mem_arbiter_if.sv
// Bundled cache-side and memory-side signals of the two-client memory arbiter.
// The slave modport is the arbiter's view; the master modport is the caches+memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  // I-cache client
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  // D-cache client
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  // main-memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging I-cache and D-cache line transactions onto one memory port.
// Every granted transaction is latched so the memory sees a stable command until mem_ready.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arbiter_if.slave bus,
  output logic [1:0]  dbg_state
);

  // Handshake: a client holds read/write (with addr/wdata) until its ready pulses for
  // one cycle; memory sees read/write held until a one-cycle mem_ready completes it.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              lat_write_q, lat_write_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic serving;

  always_comb begin
    i_req   = bus.i_read;
    d_req   = bus.d_read | bus.d_write;
    // on a tie the client that was not served last wins
    grant_i = i_req & (~d_req | last_d_q);
    grant_d = d_req & (~i_req | ~last_d_q);

    state_d     = state_q;
    last_d_d    = last_d_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_write_d = lat_write_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d     = SERVE_I;
          last_d_d    = 1'b0;
          lat_addr_d  = bus.i_addr;
          lat_write_d = 1'b0;
        end else if (grant_d) begin
          state_d     = SERVE_D;
          last_d_d    = 1'b1;
          lat_addr_d  = bus.d_addr;
          lat_wdata_d = bus.d_wdata;
          // read+write together is resolved as a write-back
          lat_write_d = bus.d_write;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_write_q <= lat_write_d;
    end
  end

  // memory side is decoded purely from registers; client inputs never reach it directly
  assign serving       = (state_q != IDLE);
  assign bus.mem_read  = serving & ~lat_write_q;
  assign bus.mem_write = serving &  lat_write_q;
  assign bus.mem_addr  = lat_addr_q;
  assign bus.mem_wdata = lat_wdata_q;

  assign bus.i_ready = (state_q == SERVE_I) & bus.mem_ready;
  assign bus.d_ready = (state_q == SERVE_D) & bus.mem_ready;
  assign bus.i_rdata = bus.i_ready ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_ready ? bus.mem_rdata : '0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single reads, write-back/read chain,
// round-robin ties, latched-input stability and the illegal read+write case.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_I    = 2'd1;
  localparam logic [1:0] S_D    = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         errors;
  int         checks;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_read    = 1'b0;
    bus.i_addr    = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // get into SERVE_D with non-zero latches, then drop reset mid-transaction
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h0ABCDE0;
    bus.d_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    tick();
    tick();
    checks++;
    if (bus.mem_write !== 1'b1) begin
      errors++; $display("FAIL reset_pre_write: got %b expected 1", bus.mem_write);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      errors++; $display("FAIL reset_async_cmd: got %b expected 00", {bus.mem_read, bus.mem_write});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      errors++; $display("FAIL reset_async_addr_data: got addr %h wdata %h expected 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({bus.i_ready, bus.d_ready} !== 2'b00 || bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
      errors++; $display("FAIL reset_async_client: got rdy %b%b d_rdata %h expected 0", bus.i_ready, bus.d_ready, bus.d_rdata);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++; $display("FAIL reset_async_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
    clear_inputs();
    #2;
    rst_n = 1'b1;
    tick();
    // stray mem_ready with no request must be ignored
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h1234;
    #1;
    checks++;
    if ({bus.i_ready, bus.d_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_stray_ready: got %b%b expected 00", bus.i_ready, bus.d_ready);
    end
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if (dbg_state !== S_IDLE || bus.mem_read !== 1'b0) begin
      errors++; $display("FAIL reset_stays_idle: got state %0d mem_read %b expected 0/0", dbg_state, bus.mem_read);
    end
  endtask

  task automatic test_single_i();
    logic [DATA_W-1:0] line;
    line = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000010;
    tick();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0000010) begin
        errors++; $display("FAIL single_i_cmd c%0d: got rd %b wr %b addr %h expected 1 0 0000010", c, bus.mem_read, bus.mem_write, bus.mem_addr);
      end
      checks++;
      if (bus.i_ready !== 1'b0 || bus.i_rdata !== '0) begin
        errors++; $display("FAIL single_i_early_ready c%0d: got %b rdata %h expected 0", c, bus.i_ready, bus.i_rdata);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = line;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1 || bus.i_rdata !== line) begin
      errors++; $display("FAIL single_i_ready: got %b rdata %h expected 1 %h", bus.i_ready, bus.i_rdata, line);
    end
    checks++;
    if (bus.d_ready !== 1'b0 || bus.d_rdata !== '0) begin
      errors++; $display("FAIL single_i_d_quiet: got %b rdata %h expected 0", bus.d_ready, bus.d_rdata);
    end
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0000010) begin
      errors++; $display("FAIL single_i_cmd_c4: got rd %b addr %h expected 1 0000010", bus.mem_read, bus.mem_addr);
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.i_read    = 1'b0;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.i_ready !== 1'b0 || bus.mem_addr !== 28'h0000010) begin
      errors++; $display("FAIL single_i_idle: got rd %b rdy %b addr %h expected 0 0 0000010", bus.mem_read, bus.i_ready, bus.mem_addr);
    end
    tick();
  endtask

  task automatic test_wb_then_read();
    logic [DATA_W-1:0] wline;
    logic [DATA_W-1:0] rline;
    wline = 128'h0102_0304_0506_0708_090A_0B0C_DEAD_BEEF;
    rline = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h0ABCDE0;
    bus.d_wdata = wline;
    tick();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 28'h0ABCDE0 || bus.mem_wdata !== wline) begin
      errors++; $display("FAIL wb_cmd: got wr %b rd %b addr %h wdata %h expected 1 0 0ABCDE0 %h", bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, wline);
    end
    tick();
    // ready cycle: client already switches to the follow-up line read
    bus.mem_ready = 1'b1;
    bus.d_write   = 1'b0;
    bus.d_read    = 1'b1;
    bus.d_addr    = 28'h0123450;
    bus.d_wdata   = '0;
    #1;
    checks++;
    if (bus.d_ready !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_addr !== 28'h0ABCDE0 || bus.mem_wdata !== wline) begin
      errors++; $display("FAIL wb_ready: got rdy %b wr %b addr %h wdata %h expected 1 1 0ABCDE0 %h", bus.d_ready, bus.mem_write, bus.mem_addr, bus.mem_wdata, wline);
    end
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if (dbg_state !== S_IDLE || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
      errors++; $display("FAIL wb_idle: got state %0d wr %b rd %b expected 0 0 0", dbg_state, bus.mem_write, bus.mem_read);
    end
    tick();
    checks++;
    if (dbg_state !== S_D || bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 28'h0123450) begin
      errors++; $display("FAIL wb_followup_read: got state %0d rd %b wr %b addr %h expected 2 1 0 0123450", dbg_state, bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rline;
    #1;
    checks++;
    if (bus.d_ready !== 1'b1 || bus.d_rdata !== rline || bus.i_ready !== 1'b0) begin
      errors++; $display("FAIL wb_followup_data: got rdy %b rdata %h expected 1 %h", bus.d_ready, bus.d_rdata, rline);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_state [4];
    exp_state[0] = S_D;
    exp_state[1] = S_I;
    exp_state[2] = S_D;
    exp_state[3] = S_I;
    apply_reset();
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000100;
    bus.d_read = 1'b1;
    bus.d_addr = 28'h0000D00;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (dbg_state !== exp_state[t] || bus.mem_addr !== ((exp_state[t] == S_D) ? 28'h0000D00 : 28'h0000100)) begin
        errors++; $display("FAIL rr_grant t%0d: got state %0d addr %h expected state %0d", t, dbg_state, bus.mem_addr, exp_state[t]);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 128'(t + 1);
      #1;
      checks++;
      if (bus.d_ready !== (exp_state[t] == S_D) || bus.i_ready !== (exp_state[t] == S_I)) begin
        errors++; $display("FAIL rr_ready t%0d: got i %b d %b expected state %0d", t, bus.i_ready, bus.d_ready, exp_state[t]);
      end
      tick();
      bus.mem_ready = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_input_change();
    bus.i_read = 1'b1;
    bus.i_addr = 28'h0000010;
    tick();
    bus.i_addr = 28'h0000020;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus.mem_addr !== 28'h0000010 || bus.mem_read !== 1'b1) begin
        errors++; $display("FAIL hold_addr c%0d: got addr %h rd %b expected 0000010 1", c, bus.mem_addr, bus.mem_read);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h77;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1 || bus.mem_addr !== 28'h0000010) begin
      errors++; $display("FAIL hold_addr_ready: got rdy %b addr %h expected 1 0000010", bus.i_ready, bus.mem_addr);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_illegal_rw();
    logic [DATA_W-1:0] wline;
    wline = 128'hBEEF_0000_1111_2222_3333_4444_5555_6666;
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_addr  = 28'h0FEDCB0;
    bus.d_wdata = wline;
    tick();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
      errors++; $display("FAIL illegal_cmd: got wr %b rd %b expected 1 0", bus.mem_write, bus.mem_read);
    end
    checks++;
    if (bus.mem_wdata !== wline || bus.mem_addr !== 28'h0FEDCB0) begin
      errors++; $display("FAIL illegal_data: got wdata %h addr %h expected %h 0FEDCB0", bus.mem_wdata, bus.mem_addr, wline);
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.d_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_ready: got %b expected 1", bus.d_ready);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_single_i();
    test_wb_then_read();
    test_round_robin();
    test_input_change();
    test_illegal_rw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client memory arbiter that sits directly downstream of the instruction cache and the data cache. It merges their 128-bit line-fill and write-back requests onto the single slow main-memory port. Each client sees an unchanged cache-side memory protocol (request held until a one-cycle ready), so both caches connect without modification. Arbitration is round-robin, and every transaction is latched, so the memory sees stable address, data and command for the whole access.

## Interface
- ADDR_W, 28, line address width (word address minus 2 offset bits)
- DATA_W, 128, cache line width
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_read  input  1  I-cache line read request
- i_addr  input  ADDR_W  I-cache line address
- i_rdata  output  DATA_W  line returned to I-cache
- i_ready  output  1  I-cache transaction complete
- d_read  input  1  D-cache line read request
- d_write  input  1  D-cache line write-back request
- d_addr  input  ADDR_W  D-cache line address
- d_wdata  input  DATA_W  D-cache write-back line
- d_rdata  output  DATA_W  line returned to D-cache
- d_ready  output  1  D-cache transaction complete
- mem_read  output  1  memory read command
- mem_write  output  1  memory write command
- mem_addr  output  ADDR_W  memory line address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  input  1  memory access complete, one-cycle pulse

## Operation
- States:
  - IDLE: no grant.
  - SERVE_I: I-cache granted.
  - SERVE_D: D-cache granted.
- Registers:
  - state
  - last_d: 1 = D-cache granted last.
  - lat_addr, lat_wdata, lat_write.
- IDLE, request detection:
  - i_req = i_read.
  - d_req = d_read | d_write.
- IDLE, grant decision:
  - Only i_req: go to SERVE_I.
  - Only d_req: go to SERVE_D.
  - Both: grant the client not served last. This is SERVE_I if last_d=1, else SERVE_D.
- On grant:
  - Latch the winner's addr into lat_addr.
  - For D only, latch wdata into lat_wdata and d_write into lat_write. lat_write=0 for I.
  - Update last_d to match the winner.
- d_read and d_write both asserted is illegal. It is treated as a write (lat_write=1).
- SERVE_x: drive the memory from the latches only. Client inputs are ignored until the state returns to IDLE.
  - mem_addr = lat_addr.
  - mem_wdata = lat_wdata.
  - mem_write = lat_write.
  - mem_read = ~lat_write.
- SERVE_x with mem_ready=1:
  - x_ready=1 for that cycle (combinational).
  - x_rdata = mem_rdata (combinational).
  - The state returns to IDLE next.
- The other client's ready is always 0, and its rdata is 0.
- x_rdata is 0 whenever x_ready=0.
- IDLE:
  - mem_read and mem_write are 0.
  - mem_addr holds its last value; mem_wdata holds its last value.
  - mem_ready is ignored.
- Clients hold their request until ready. A request still asserted in the IDLE cycle after its own ready is treated as a new transaction. This supports the D-cache write-back followed by line read sequence.
- Reset, asynchronous, including mid-transaction:
  - state=IDLE, last_d=0 (D wins the first tie).
  - All latches=0.
  - All outputs=0.
  - An abandoned memory access is not completed. A mem_ready arriving after reset is ignored.

## Timing
- Request sampled in IDLE at cycle 0. The memory command is asserted from cycle 1.
- If mem_ready arrives at cycle 1+L (L≥0 memory wait cycles), client ready occurs at cycle 1+L. The next grant can happen at the earliest at cycle 2+L, in IDLE.
- Arbiter overhead: 1 cycle (IDLE) per transaction. No combinational path from client request to mem_*; all mem_* outputs come from registers.
- Only ready/rdata are combinational from mem_ready/mem_rdata.
- Worst-case wait for a client under continuous contention: one full transaction of the other client.
- Memory command, address and write data are stable from grant until the mem_ready cycle inclusive.

## Test plan
- Reset, with rst_n low mid-SERVE_D:
  - All outputs are 0 immediately, without waiting for clk.
  - After release, a mem_ready pulse with no request produces no client ready.
- Single I read, i_addr=0x0000010, memory L=3:
  - mem_read=1 with mem_addr=0x0000010 during cycles 1–4.
  - i_ready=1 and i_rdata=mem_rdata at cycle 4 only.
  - d_ready stays 0.
- D write-back then read:
  - d_write with addr 0x0ABCDE0 and wdata 0x…DEAD_BEEF gives mem_write=1 with that data.
  - d_read to addr 0x0123450 is asserted in the ready cycle.
  - The next IDLE cycle grants SERVE_D with mem_read=1, addr 0x0123450.
- Simultaneous requests after reset:
  - The first grant goes to D.
  - With both kept asserted, grants alternate D, I, D, I over 4 transactions.
- Input change during grant:
  - In SERVE_I, i_addr changes to 0x0000020 while memory is stalled.
  - mem_addr stays 0x0000010 until i_ready.
- Illegal d_read=d_write=1:
  - mem_write=1, mem_read=0.
  - Data is taken from d_wdata.
